// File: rtl/uart_rx.sv
// uart_rx: console UART receiver, 8N1, the receive-side counterpart of the
// UART transmit path. Received bytes go into a small FIFO. The core reads
// the FIFO and status through a single memory-mapped register.
//
// Ports:
//   clock         system clock; all logic on the rising edge
//   reset         synchronous, active-high
//   rx            asynchronous serial input, idles high
//   memory_valid  request strobe, one cycle per request
//   memory_instr  fetch flag, handled the same as a data read
//   memory_addr   ignored; the block has a single register
//   memory_wdata  ignored
//   memory_wstrb  zero = read, non-zero = write (no effect on state)
//   memory_rdata  {nonempty, overflow, frame_err, 21'b0, head_byte} while ready
//   memory_ready  one-cycle response pulse, the cycle after memory_valid
//   rx_irq        high while the FIFO holds data
//
// state | meaning
// IDLE  | line idle, waiting for a 1->0 edge on rx_s
// START | timing to the middle of the start bit to reject glitches
// DATA  | sampling 8 data bits at bit centre, LSB first
// STOP  | sampling the stop bit; push the byte or flag a framing error

module uart_rx #(
  parameter int CLKS_PER_BIT = 216,
  parameter int DEPTH        = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready,
  output logic        rx_irq
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic             rx_m, rx_s, rx_s_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  logic             fall;
  logic             half_hit, bit_hit;
  logic             cnt_clr, shift_en, stop_sample;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             nonempty;
  logic             overflow, frame_err;
  logic             rd_req, pop, push_req, push, ovf_set, ferr_set;
  logic [7:0]       head_byte;

  logic             unused_inputs;
  assign unused_inputs = ^{memory_instr, memory_addr, memory_wdata};

  // Two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign fall     = !rx_s && rx_s_d;
  assign half_hit = (cnt == CNT_HALF);
  assign bit_hit  = (cnt == CNT_FULL);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (bit_hit && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:  if (bit_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr     = 1'b0;
    shift_en    = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE:  cnt_clr = 1'b1;
      START: cnt_clr = half_hit;
      DATA: begin
        cnt_clr  = bit_hit;
        shift_en = bit_hit;
      end
      STOP: begin
        cnt_clr     = bit_hit;
        stop_sample = bit_hit;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Bit timing and shift register. Restarting cnt from 0 at each sample
  // keeps every following sample a full CLKS_PER_BIT+1 clocks later, so
  // sampling stays at the bit centre found in START.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (state == START)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + 1'b1;
      if (shift_en)
        shift_reg <= {rx_s, shift_reg[7:1]};
    end
  end

  assign nonempty  = (count != '0);
  assign rd_req    = memory_valid && (memory_wstrb == 4'b0);
  assign pop       = rd_req && nonempty;
  assign push_req  = stop_sample && rx_s;
  assign ferr_set  = stop_sample && !rx_s;
  // A full FIFO still accepts a byte when a read frees a slot this cycle.
  assign push      = push_req && ((count < CNT_DEPTH) || pop);
  assign ovf_set   = push_req && !push;
  assign head_byte = nonempty ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags; a read clears them, but an event in the same cycle wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovf_set)     overflow <= 1'b1;
      else if (rd_req) overflow <= 1'b0;
      if (ferr_set)    frame_err <= 1'b1;
      else if (rd_req) frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      memory_ready <= 1'b0;
      memory_rdata <= '0;
      rx_irq       <= 1'b0;
    end else begin
      memory_ready <= memory_valid;
      memory_rdata <= rd_req ? {nonempty, overflow, frame_err, 21'b0, head_byte} : 32'h0;
      rx_irq       <= nonempty;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int BIT_CLKS = 217;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        memory_valid = 1'b0;
  logic        memory_instr = 1'b0;
  logic [31:0] memory_addr = 32'h0100_0000;
  logic [31:0] memory_wdata = 32'h0;
  logic [3:0]  memory_wstrb = 4'h0;
  logic [31:0] memory_rdata;
  logic        memory_ready;
  logic        rx_irq;

  int total = 0;
  int bad = 0;

  uart_rx dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .memory_valid (memory_valid),
    .memory_instr (memory_instr),
    .memory_addr  (memory_addr),
    .memory_wdata (memory_wdata),
    .memory_wstrb (memory_wstrb),
    .memory_rdata (memory_rdata),
    .memory_ready (memory_ready),
    .rx_irq       (rx_irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input logic level);
    rx = level;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_level);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop_level);
    rx = 1'b1;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] exp);
    @(negedge clock);
    memory_valid = 1'b1;
    memory_wstrb = 4'h0;
    @(negedge clock);
    memory_valid = 1'b0;
    check({tag, ".ready"}, {31'b0, memory_ready}, 32'd1);
    check({tag, ".rdata"}, memory_rdata, exp);
    @(negedge clock);
    check({tag, ".ready_low"}, {31'b0, memory_ready}, 32'd0);
    check({tag, ".rdata_low"}, memory_rdata, 32'h0);
  endtask

  task automatic bus_write(input string tag);
    @(negedge clock);
    memory_valid = 1'b1;
    memory_wstrb = 4'hF;
    memory_wdata = 32'hFFFF_FFFF;
    @(negedge clock);
    memory_valid = 1'b0;
    memory_wstrb = 4'h0;
    check({tag, ".ready"}, {31'b0, memory_ready}, 32'd1);
    check({tag, ".rdata"}, memory_rdata, 32'h0);
    @(negedge clock);
    check({tag, ".ready_low"}, {31'b0, memory_ready}, 32'd0);
  endtask

  initial begin
    // Reset and idle line
    wait_clks(4);
    check("rst.ready", {31'b0, memory_ready}, 32'd0);
    check("rst.rdata", memory_rdata, 32'h0);
    check("rst.irq", {31'b0, rx_irq}, 32'd0);
    reset = 1'b0;
    wait_clks(5000);
    check("idle.irq", {31'b0, rx_irq}, 32'd0);
    bus_read("idle.rd", 32'h0000_0000);

    // Single byte 0x55, irq timing around the stop-bit sample
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(((8'h55 >> i) & 8'h01) != 0);
    rx = 1'b1;
    wait_clks(100);
    check("b55.irq_before_stop", {31'b0, rx_irq}, 32'd0);
    wait_clks(BIT_CLKS - 100);
    check("b55.irq_after_stop", {31'b0, rx_irq}, 32'd1);
    bus_read("b55.rd1", 32'h8000_0055);
    bus_read("b55.rd2", 32'h0000_0000);
    check("b55.irq_empty", {31'b0, rx_irq}, 32'd0);

    // 17 back-to-back bytes: FIFO fills, 0x10 overflows
    for (int b = 0; b < 17; b++) send_frame(8'(b), 1'b1);
    wait_clks(20);
    check("ovf.irq", {31'b0, rx_irq}, 32'd1);
    bus_read("ovf.rd0", 32'hC000_0000);
    for (int b = 1; b < 16; b++) bus_read("ovf.rdn", 32'h8000_0000 | 32'(b));
    bus_read("ovf.rd_empty", 32'h0000_0000);
    check("ovf.irq_empty", {31'b0, rx_irq}, 32'd0);

    // Framing error: stop bit held low
    send_frame(8'hA5, 1'b0);
    wait_clks(300);
    check("ferr.irq", {31'b0, rx_irq}, 32'd0);
    bus_read("ferr.rd1", 32'h2000_0000);
    bus_read("ferr.rd2", 32'h0000_0000);

    // Glitch shorter than half a bit
    rx = 1'b0;
    wait_clks(50);
    rx = 1'b1;
    wait_clks(3 * BIT_CLKS);
    check("glitch.irq", {31'b0, rx_irq}, 32'd0);
    bus_read("glitch.rd", 32'h0000_0000);
    send_frame(8'h3C, 1'b1);
    wait_clks(10);
    bus_read("b3c.rd", 32'h8000_003C);

    // Reset in the middle of bit 4 of 0xFF discards the partial byte
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    wait_clks(100);
    reset = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(6 * BIT_CLKS);
    check("midrst.irq", {31'b0, rx_irq}, 32'd0);
    send_frame(8'h12, 1'b1);
    wait_clks(10);
    check("b12.irq", {31'b0, rx_irq}, 32'd1);
    bus_write("wr");
    check("wr.irq", {31'b0, rx_irq}, 32'd1);
    bus_read("b12.rd1", 32'h8000_0012);
    bus_read("b12.rd2", 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the console UART; the receive-side counterpart of the existing UART transmit path.
- Deserialises 8N1 frames from the `rx` pin into a byte FIFO.
- Exposes FIFO data plus status through the core's memory-mapped request/ready interface in the UART window (0x1000000–0x1000004).
- Address decode happens upstream; this block responds to every `memory_valid` it receives.

Parameters:
- CLKS_PER_BIT, 216, bit period minus one, in clocks: clk_freq/baudrate-1 (25 MHz / 115200 baud).
- DEPTH, 16, receive FIFO entries; power of two, at least 2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial input; idles high.
- memory_valid  input  1  request strobe, one cycle per request.
- memory_instr  input  1  instruction fetch flag; treated the same as a data read.
- memory_addr  input  32  request address; ignored (single register).
- memory_wdata  input  32  write data; ignored.
- memory_wstrb  input  4  zero means read; non-zero means write.
- memory_rdata  output  32  read data, valid while memory_ready is 1.
- memory_ready  output  1  one-cycle response pulse.
- rx_irq  output  1  high while the FIFO is non-empty.

Behaviour:
- Reset values:
  - memory_ready=0, memory_rdata=0, rx_irq=0.
  - FIFO empty; read/write pointers and count = 0.
  - overflow=0, frame_err=0.
  - FSM in IDLE, bit counter=0, synchroniser flops=1.
  - Reset mid-frame discards the partial byte.
- Input synchronisation: rx passes through 2 flops (rx_s). A falling edge is rx_s=0 with the previous rx_s=1.
- FSM states: IDLE, START, DATA, STOP. The counter cnt counts clocks within a bit.
- IDLE:
  - On a falling edge: cnt=0, go to START.
- START:
  - When cnt==CLKS_PER_BIT/2 (integer divide), sample rx_s.
  - rx_s=0: cnt=0, bit index=0, go to DATA.
  - rx_s=1: glitch; return to IDLE with no side effects.
- DATA:
  - When cnt==CLKS_PER_BIT, shift rx_s into the byte LSB-first, cnt=0, increment the index.
  - After the 8th sample, go to STOP.
  - A full bit period is CLKS_PER_BIT+1 clocks, so sampling stays at bit centre.
- STOP:
  - When cnt==CLKS_PER_BIT, sample rx_s and go to IDLE.
  - rx_s=1: push the byte.
  - rx_s=0: set frame_err (sticky) and drop the byte.
  - A low stop bit does not create a false start: IDLE needs a new 1→0 edge.
- FIFO push:
  - Push when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle.
  - Otherwise drop the byte and set overflow (sticky).
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- Bus access:
  - memory_valid=1 gives memory_ready=1 exactly one cycle later, for exactly one cycle. No stalls.
  - A new request may arrive in the cycle ready is high.
- Read (wstrb==0), captured at request time:
  - rdata = {nonempty, overflow, frame_err, 21'b0, head_byte}.
  - head_byte is 0 when the FIFO is empty.
  - Pop if non-empty.
  - Clear overflow and frame_err in the same cycle; a flag set by an event in that cycle wins over the clear.
- Write (wstrb!=0): ready pulse, rdata=0, no state change.
- memory_rdata returns to 0 in any cycle without ready.
- rx_irq is registered from count!=0 and updates one cycle after push or pop.

Test Plan:
- Reset, then rx held at 1 for 5000 clocks → rx_irq=0. A read returns rdata=0x00000000 with ready exactly 1 cycle after valid.
- Send frame 0x55 (start, 10101010 LSB-first, stop), 217 clocks/bit:
  - rx_irq rises about 2 clocks after stop-bit sampling.
  - Read → 0x80000055.
  - Second read → 0x00000000; rx_irq=0.
- Send 17 back-to-back bytes 0x00..0x10 with no reads:
  - First read → 0xC0000000, i.e. nonempty+overflow, data 0x00.
  - Next 15 reads return 0x80000001..0x8000000F with the overflow bit clear.
  - 17th read → 0x00000000; byte 0x10 was dropped.
- Frame 0xA5 with stop bit held 0 for one bit, then rx=1:
  - FIFO stays empty.
  - Read → 0x20000000.
  - Next read → 0x00000000.
- Glitch: rx low for 50 clocks then high (shorter than half-bit 108) → no byte, no flags. A valid 0x3C sent afterwards reads 0x8000003C.
- Reset asserted in the middle of frame 0xFF bit 4, then frame 0x12 sent → read returns 0x80000012 only. A write with wstrb=0xF and wdata=0xFFFFFFFF has no effect.
